// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: header layout, CRC constants and FSM encoding shared by the frame strobe sequencer
package frame_cfg_pkg;
  localparam logic [7:0] FRAME_MAGIC = 8'hFA;
  localparam int MAGIC_MSB = 31;
  localparam int MAGIC_LSB = 24;
  localparam int IDX_MSB = 4;
  localparam int IDX_LSB = 0;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  typedef enum logic [2:0] {HDR, DROP, DATA, SETUP, STROBE, HOLD} frameState_t;
endpackage

// File: rtl/frame_crc16.sv
// frame_crc16: one 32-bit MSB-first step of CRC-16-CCITT, purely combinational
module frame_crc16
  import frame_cfg_pkg::*;
(
  input  logic [15:0] crcIn,
  input  logic [31:0] data,
  output logic [15:0] crcOut
);
  always_comb begin
    crcOut = crcIn;
    for (int i = 31; i >= 0; i--)
      crcOut = {crcOut[14:0], 1'b0} ^ ((crcOut[15] ^ data[i]) ? CRC16_POLY : 16'h0000);
  end
endmodule

// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer: header/data stream to one-hot frame strobes with setup/hold; FRAME_CRC_EN adds a crc output
module frame_strobe_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FrameBitsPerRow-1:0] s_data,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr,
  output logic [15:0]                frames_written
`ifdef FRAME_CRC_EN
  ,
  output logic [15:0]                crc
`endif
);
  frameState_t state, stateNext;
  logic [4:0] idx;
  logic xfer, magicOk, idxOk, errSet;
  assign s_ready = state inside {HDR, DROP, DATA};
  assign busy = state != HDR;
  assign xfer = s_valid && s_ready;
  assign magicOk = s_data[MAGIC_MSB:MAGIC_LSB] == FRAME_MAGIC;
  assign idxOk = int'(s_data[IDX_MSB:IDX_LSB]) < MaxFramesPerCol;
  assign errSet = xfer && state == HDR && !(magicOk && idxOk);
  always_comb begin
    stateNext = state;
    case (state)
      HDR:     if (xfer) stateNext = !magicOk ? HDR : idxOk ? DATA : DROP;
      DROP:    if (xfer) stateNext = HDR;
      DATA:    if (xfer) stateNext = SETUP;
      SETUP:   stateNext = STROBE;
      STROBE:  stateNext = HOLD;
      default: stateNext = HDR;
    endcase
  end
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      state <= HDR;
      idx <= '0;
      FrameData <= '0;
      FrameStrobe <= '0;
      err <= 1'b0;
      frames_written <= '0;
    end else begin
      state <= stateNext;
      if (xfer && state == HDR && magicOk && idxOk) idx <= s_data[IDX_MSB:IDX_LSB];
      if (xfer && state == DATA) FrameData <= s_data;
      FrameStrobe <= state == SETUP ? MaxFramesPerCol'(1) << idx : '0;
      if (state == STROBE) frames_written <= frames_written + 16'd1;
      err <= errSet || (err && !err_clr);
    end
`ifdef FRAME_CRC_EN
  logic [15:0] crcNext;
  frame_crc16 u_crc (.crcIn(crc), .data(FrameData), .crcOut(crcNext));
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) crc <= CRC16_INIT;
    else if (err_clr) crc <= CRC16_INIT;
    else if (state == STROBE) crc <= crcNext;
`endif
endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// tb_frame_strobe_sequencer: timeline reference model, directed pins and random stream for frame_strobe_sequencer
module tb_frame_strobe_sequencer;
  localparam int NF = 20;
  logic CLK = 1'b0;
  logic resetn = 1'b0;
  logic s_valid = 1'b0;
  logic err_clr = 1'b0;
  logic [31:0] s_data = '0;
  logic s_ready, busy, err;
  logic [31:0] FrameData;
  logic [NF-1:0] FrameStrobe;
  logic [15:0] frames_written;
`ifdef FRAME_CRC_EN
  logic [15:0] crc;
`endif
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  frame_strobe_sequencer #(.MaxFramesPerCol(NF), .FrameBitsPerRow(32)) dut (
    .CLK(CLK), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .err(err),
    .err_clr(err_clr), .frames_written(frames_written)
`ifdef FRAME_CRC_EN
    , .crc(crc)
`endif
  );
  int cyc, dataCyc, mode;
  logic [4:0] mIdx, sIdx;
  logic [31:0] mData;
  logic mErr;
  logic [15:0] mCount;
`ifdef FRAME_CRC_EN
  logic [15:0] mCrc;
  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? (r << 1) ^ 16'h1021 : r << 1;
    return r;
  endfunction
  function automatic logic [15:0] crcWord(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 3; i >= 0; i--) r = crcByte(r, w[i*8 +: 8]);
    return r;
  endfunction
`endif
  function automatic logic locked();
    return cyc >= dataCyc + 1 && cyc <= dataCyc + 3;
  endfunction
  task automatic mReset();
    cyc = 0;
    dataCyc = -100;
    mode = 0;
    mIdx = '0;
    sIdx = '0;
    mData = '0;
    mErr = 1'b0;
    mCount = '0;
`ifdef FRAME_CRC_EN
    mCrc = 16'hFFFF;
`endif
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask
  task automatic compare();
    logic lk;
    lk = locked();
    chk("s_ready", 32'(s_ready), 32'(!lk));
    chk("busy", 32'(busy), 32'(mode != 0 || lk));
    chk("FrameData", FrameData, mData);
    chk("FrameStrobe", 32'(FrameStrobe), cyc == dataCyc + 2 ? 32'd1 << sIdx : 32'd0);
    chk("err", 32'(err), 32'(mErr));
    chk("frames_written", 32'(frames_written), 32'(mCount));
`ifdef FRAME_CRC_EN
    chk("crc", 32'(crc), 32'(mCrc));
`endif
  endtask
  task automatic step();
    logic setErr;
    setErr = 1'b0;
    if (s_valid && !locked()) begin
      if (mode == 1) begin
        dataCyc = cyc;
        mData = s_data;
        sIdx = mIdx;
        mode = 0;
      end else if (mode == 2) mode = 0;
      else if (s_data[31:24] != 8'hFA) setErr = 1'b1;
      else if (int'(s_data[4:0]) >= NF) begin
        setErr = 1'b1;
        mode = 2;
      end else begin
        mIdx = s_data[4:0];
        mode = 1;
      end
    end
`ifdef FRAME_CRC_EN
    if (err_clr) mCrc = 16'hFFFF;
    else if (cyc == dataCyc + 2) mCrc = crcWord(mCrc, mData);
`endif
    if (cyc == dataCyc + 2) mCount++;
    mErr = setErr || (mErr && !err_clr);
    cyc++;
  endtask
  task automatic tick(input logic v, input logic [31:0] d, input logic c);
    s_valid = v;
    s_data = d;
    err_clr = c;
    @(posedge CLK);
    step();
    @(negedge CLK);
    compare();
  endtask
  initial begin
    mReset();
    repeat (2) @(negedge CLK);
    compare();
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_strobe", 32'(FrameStrobe), 32'd0);
`ifdef FRAME_CRC_EN
    chk("rst_crc", 32'(crc), 32'hFFFF);
    begin
      logic [15:0] r;
      logic [71:0] s;
      s = "123456789";
      r = 16'hFFFF;
      for (int i = 8; i >= 0; i--) r = crcByte(r, s[i*8 +: 8]);
      chk("model_crc_check", 32'(r), 32'h29B1);
    end
`endif
    resetn = 1'b1;
    tick(1, 32'hFA000003, 0);
    chk("hdr_busy", 32'(busy), 32'd1);
    tick(1, 32'hDEADBEEF, 0);
    chk("setup_data", FrameData, 32'hDEADBEEF);
    chk("setup_strobe", 32'(FrameStrobe), 32'd0);
    tick(0, 32'h0, 0);
    chk("strobe_bit3", 32'(FrameStrobe), 32'h00008);
    tick(0, 32'h0, 0);
    chk("hold_strobe", 32'(FrameStrobe), 32'd0);
    chk("hold_count", 32'(frames_written), 32'd1);
    tick(0, 32'h0, 0);
    tick(1, 32'h12000001, 0);
    chk("bad_magic_err", 32'(err), 32'd1);
    chk("bad_magic_busy", 32'(busy), 32'd0);
    tick(1, 32'hFA000000, 0);
    tick(1, 32'h00000001, 0);
    tick(0, 32'h0, 0);
    chk("strobe_bit0", 32'(FrameStrobe), 32'h00001);
    chk("err_sticky", 32'(err), 32'd1);
    tick(0, 32'h0, 0);
    tick(0, 32'h0, 1);
    chk("err_cleared", 32'(err), 32'd0);
`ifdef FRAME_CRC_EN
    chk("crc_cleared", 32'(crc), 32'hFFFF);
`endif
    tick(1, 32'hFA000018, 0);
    chk("bad_idx_err", 32'(err), 32'd1);
    chk("drop_busy", 32'(busy), 32'd1);
    tick(1, 32'hCAFEF00D, 0);
    chk("drop_done", 32'(busy), 32'd0);
    tick(1, 32'hFA000005, 0);
    tick(1, 32'h00000055, 0);
    tick(0, 32'h0, 0);
    chk("strobe_bit5", 32'(FrameStrobe), 32'h00020);
    tick(0, 32'h0, 0);
    chk("count3", 32'(frames_written), 32'd3);
    tick(0, 32'h0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, 32'hFA000000 | 32'(i), 0);
      tick(1, 32'h1000 + 32'(i), 0);
      repeat (3) tick(1, 32'hFFFFFFFF, 0);
    end
    chk("count7", 32'(frames_written), 32'd7);
    tick(1, 32'hFA000007, 0);
    tick(1, 32'h77777777, 0);
    tick(0, 32'h0, 0);
    chk("pre_reset_strobe", 32'(FrameStrobe), 32'h00080);
    #2 resetn = 1'b0;
    #1;
    chk("async_strobe", 32'(FrameStrobe), 32'd0);
    chk("async_data", FrameData, 32'd0);
    chk("async_count", 32'(frames_written), 32'd0);
    chk("async_ready", 32'(s_ready), 32'd1);
    mReset();
    @(negedge CLK);
    compare();
    resetn = 1'b1;
    repeat (6) tick(0, 32'h0, 0);
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [31:0] w;
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r < 5) w = {8'hFA, w[23:5], 5'($urandom_range(0, NF - 1))};
      else if (r == 5) w = {8'hFA, w[23:5], 5'($urandom_range(NF, 31))};
      tick($urandom_range(0, 3) != 0, w, $urandom_range(0, 19) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
